control_loop_sequencer: RTL

Sequences one iteration of the wall-follower control loop at a fixed rate. A periodic loop tick starts a distance-sensor measurement. The captured sample is handed to the PID compute unit, and the PWM stage is told to latch the new output. The block sits between the system clock domain's rate divider and the sensor, PID and PWM datapath. It detects iterations that overrun the loop period and handshakes that hang.

---
 rtl/control_loop_sequencer_pkg.sv | 14 +
 rtl/control_loop_sequencer_if.sv | 36 +++
 rtl/control_loop_sequencer_clk_enable.sv | 35 +++
 rtl/control_loop_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/control_loop_sequencer_pkg.sv
// Shared types and constants for the control-loop sequencer.
//   loop_state_e : sequencer FSM states
//   OvrCntW      : width of the saturating dropped-tick counter
package control_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StSenseWait = 2'd1,
    StPidWait   = 2'd2
  } loop_state_e;

  localparam int unsigned OvrCntW = 8;

endpackage

// File: rtl/control_loop_sequencer_if.sv
// Handshake bundle between the sequencer and the sensor / PID / PWM datapath.
//   master : sequencer side (drives start pulses, measurement, PWM update)
//   slave  : datapath side (drives done strobes and the sensor sample)
interface control_loop_sequencer_if #(
  parameter int unsigned DW = 12
) ();

  logic          sense_start_out;
  logic          sense_done_in;
  logic [DW-1:0] sense_data_in;
  logic          pid_start_out;
  logic [DW-1:0] pid_meas_out;
  logic          pid_done_in;
  logic          pwm_update_out;

  modport master (
    output sense_start_out,
    output pid_start_out,
    output pid_meas_out,
    output pwm_update_out,
    input  sense_done_in,
    input  sense_data_in,
    input  pid_done_in
  );

  modport slave (
    input  sense_start_out,
    input  pid_start_out,
    input  pid_meas_out,
    input  pwm_update_out,
    output sense_done_in,
    output sense_data_in,
    output pid_done_in
  );

endinterface

// File: rtl/control_loop_sequencer_clk_enable.sv
// Free-running rate divider: counts 0..DIVISOR and raises tick_o for one cycle
// while the count sits at DIVISOR, giving a period of DIVISOR+1 cycles.
//   clk_in   : system clock
//   reset_in : asynchronous active-high reset
//   tick_o   : one-cycle rate tick
module control_loop_sequencer_clk_enable #(
  parameter int unsigned DIVISOR = 1
) (
  input  logic clk_in,
  input  logic reset_in,
  output logic tick_o
);

  localparam int unsigned CntW = (DIVISOR < 1) ? 1 : $clog2(DIVISOR + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    tick_o = 1'b0;
    if (cnt_q == CntW'(DIVISOR)) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/control_loop_sequencer.sv
// Sequences one wall-follower control-loop iteration per rate tick:
// sensor start -> capture sample -> PID start -> PWM update. Flags waits that
// exceed TIMEOUT cycles and counts ticks dropped while an iteration is running.
//   clk_in / reset_in : clock, asynchronous active-high reset
//   enable_in         : gates the start of new iterations
//   loop_if           : sensor / PID / PWM handshake (master side)
//   busy_out          : iteration in progress
//   timeout_out       : one-cycle pulse on a hung wait
//   sense_fault_out   : sticky sensor timeout flag, cleared by a good sample
//   overrun_cnt_out   : saturating count of dropped ticks
module control_loop_sequencer
  import control_loop_sequencer_pkg::*;
#(
  parameter int unsigned LOOP_DIV = 999_999,
  parameter int unsigned TIMEOUT  = 500_000,
  parameter int unsigned DW       = 12
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      enable_in,
  control_loop_sequencer_if.master  loop_if,
  output logic                      busy_out,
  output logic                      timeout_out,
  output logic                      sense_fault_out,
  output logic [OvrCntW-1:0]        overrun_cnt_out
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  logic tick;

  loop_state_e         state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [DW-1:0]       meas_q, meas_d;
  logic [OvrCntW-1:0]  ovr_q, ovr_d;
  logic                sense_start_q, sense_start_d;
  logic                pid_start_q, pid_start_d;
  logic                pwm_update_q, pwm_update_d;
  logic                timeout_q, timeout_d;
  logic                fault_q, fault_d;

  control_loop_sequencer_clk_enable #(
    .DIVISOR (LOOP_DIV)
  ) u_clk_enable (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .tick_o   (tick)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    meas_d        = meas_q;
    ovr_d         = ovr_q;
    sense_start_d = 1'b0;
    pid_start_d   = 1'b0;
    pwm_update_d  = 1'b0;
    timeout_d     = 1'b0;
    fault_d       = fault_q;

    unique case (state_q)
      StIdle: begin
        if (tick && enable_in) begin
          sense_start_d = 1'b1;
          timer_d       = '0;
          state_d       = StSenseWait;
        end
      end
      StSenseWait: begin
        // A done in the same cycle the timer expires takes priority.
        if (loop_if.sense_done_in) begin
          meas_d      = loop_if.sense_data_in;
          fault_d     = 1'b0;
          pid_start_d = 1'b1;
          timer_d     = '0;
          state_d     = StPidWait;
        end else if (timer_q == TimerW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          fault_d   = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StPidWait: begin
        if (loop_if.pid_done_in) begin
          pwm_update_d = 1'b1;
          state_d      = StIdle;
        end else if (timer_q == TimerW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Ticks landing mid-iteration are dropped and counted, regardless of enable.
    if (tick && (state_q != StIdle) && (ovr_q != '1)) begin
      ovr_d = ovr_q + OvrCntW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      meas_q        <= '0;
      ovr_q         <= '0;
      sense_start_q <= 1'b0;
      pid_start_q   <= 1'b0;
      pwm_update_q  <= 1'b0;
      timeout_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      meas_q        <= meas_d;
      ovr_q         <= ovr_d;
      sense_start_q <= sense_start_d;
      pid_start_q   <= pid_start_d;
      pwm_update_q  <= pwm_update_d;
      timeout_q     <= timeout_d;
      fault_q       <= fault_d;
    end
  end

  assign loop_if.sense_start_out = sense_start_q;
  assign loop_if.pid_start_out   = pid_start_q;
  assign loop_if.pid_meas_out    = meas_q;
  assign loop_if.pwm_update_out  = pwm_update_q;
  assign busy_out                = (state_q != StIdle);
  assign timeout_out             = timeout_q;
  assign sense_fault_out         = fault_q;
  assign overrun_cnt_out         = ovr_q;

endmodule
